// File: rtl/uart_tx_capture_pkg.sv
// Shared types and constants for the UART line capture block.
package uart_tx_capture_pkg;

    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_cap_state_t;

    // Rounded clock cycles per bit.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_cap_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is accepted only
// when a pop retires the head in the same cycle, otherwise it is dropped.
module uart_cap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             push_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign push_drop = push && full && !pop_ok;
    assign pop_data  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/uart_tx_capture.sv
// 8N1 deserializer for the Qsys UART txd line feeding a byte FIFO stream.
// Define UART_TX_CAPTURE_PARITY_EN for an even-parity bit and err_parity output.
module uart_tx_capture
    import uart_tx_capture_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 err_frame,
    output logic                 err_overrun,
`ifdef UART_TX_CAPTURE_PARITY_EN
    output logic                 err_parity,
`endif
    input  logic                 err_clear,
    output uart_cap_state_t      dbg_state
);

    localparam int BAUD_DIV = baud_div(CLK_HZ, BAUD);
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int IDX_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    uart_cap_state_t        state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   err_frame_q, err_frame_d;
    logic                   err_overrun_q, err_overrun_d;
    logic                   rxs;
    logic                   fifo_push;
    logic                   fifo_drop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   frame_set;
`ifdef UART_TX_CAPTURE_PARITY_EN
    logic                   err_parity_q, err_parity_d;
    logic                   parity_set;
`endif

    assign rxs = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], rxd};
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_push = 1'b0;
        frame_set = 1'b0;
`ifdef UART_TX_CAPTURE_PARITY_EN
        parity_set = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    cnt_d   = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                // Mid-start-bit recheck filters short low glitches.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rxs) begin
                    state_d = IDLE;
                end else begin
                    cnt_d     = FULL_LOAD;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
                    cnt_d     = FULL_LOAD;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_CAPTURE_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_CAPTURE_PARITY_EN
            PARITY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    parity_set = ^{shift_q, rxs};
                    cnt_d      = FULL_LOAD;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rxs) begin
                    fifo_push = 1'b1;
                    state_d   = IDLE;
                end else begin
                    frame_set = 1'b1;
                    state_d   = BREAK;
                end
            end
            BREAK: begin
                // Held-low line: wait for idle so only one error is raised.
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        err_frame_d   = err_clear ? 1'b0 : (err_frame_q | frame_set);
        err_overrun_d = err_clear ? 1'b0 : (err_overrun_q | fifo_drop);
`ifdef UART_TX_CAPTURE_PARITY_EN
        err_parity_d  = err_clear ? 1'b0 : (err_parity_q | parity_set);
`endif
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync_q        <= '1;
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            err_frame_q   <= 1'b0;
            err_overrun_q <= 1'b0;
`ifdef UART_TX_CAPTURE_PARITY_EN
            err_parity_q  <= 1'b0;
`endif
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            err_frame_q   <= err_frame_d;
            err_overrun_q <= err_overrun_d;
`ifdef UART_TX_CAPTURE_PARITY_EN
            err_parity_q  <= err_parity_d;
`endif
        end
    end

    uart_cap_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_clk),
        .rst       (reset_reset),
        .push      (fifo_push),
        .push_data (shift_q),
        .pop       (m_ready),
        .pop_data  (m_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .push_drop (fifo_drop)
    );

    // fifo_full only feeds the drop decision inside the FIFO; kept for visibility.
    logic fifo_full_unused;
    assign fifo_full_unused = fifo_full;

    assign m_valid     = !fifo_empty;
    assign err_frame   = err_frame_q;
    assign err_overrun = err_overrun_q;
`ifdef UART_TX_CAPTURE_PARITY_EN
    assign err_parity  = err_parity_q;
`endif
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_capture.sv
// Directed bench for uart_tx_capture at a reduced bit period (20 clocks per bit).
module tb_uart_tx_capture;
    import uart_tx_capture_pkg::*;

    localparam int CLK_HZ = 2000000;
    localparam int BAUD   = 100000;
    localparam int DEPTH  = 16;
    localparam int BD     = 20;  // (2000000 + 50000) / 100000
`ifdef UART_TX_CAPTURE_PARITY_EN
    localparam int NSAMP  = 10;
`else
    localparam int NSAMP  = 9;
`endif
    // Negedges from driving the start bit until m_valid is seen high:
    // 2 sync stages + half bit + NSAMP full bits + 1 cycle for the FIFO push.
    localparam int VALID_LAT = 2 + BD / 2 + NSAMP * BD + 1;
    localparam int STOP_NEG  = VALID_LAT - 1;

    logic            clk_clk = 1'b0;
    logic            reset_reset;
    logic            rxd;
    logic [7:0]      m_data;
    logic            m_valid;
    logic            m_ready;
    logic            err_frame;
    logic            err_overrun;
    logic            err_clear;
    uart_cap_state_t dbg_state;
`ifdef UART_TX_CAPTURE_PARITY_EN
    logic            err_parity;
    logic            par_flip = 1'b0;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    always #5 clk_clk = ~clk_clk;

    uart_tx_capture #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .rxd         (rxd),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .err_frame   (err_frame),
        .err_overrun (err_overrun),
`ifdef UART_TX_CAPTURE_PARITY_EN
        .err_parity  (err_parity),
`endif
        .err_clear   (err_clear),
        .dbg_state   (dbg_state)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Start bit, LSB-first data, optional parity, stop level held stop_cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_cycles);
        @(negedge clk_clk);
        rxd = 1'b0;
        repeat (BD) @(negedge clk_clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BD) @(negedge clk_clk);
        end
`ifdef UART_TX_CAPTURE_PARITY_EN
        rxd = (^b) ^ par_flip;
        repeat (BD) @(negedge clk_clk);
`endif
        rxd = stop_bit;
        repeat (stop_cycles) @(negedge clk_clk);
        rxd = 1'b1;
    endtask

    task automatic pop_one();
        m_ready = 1'b1;
        @(negedge clk_clk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        rxd         = 1'b1;
        m_ready     = 1'b0;
        err_clear   = 1'b0;
        #23;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", m_data); end
        n_checks++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL reset_err_frame: got %b want 0", err_frame); end
        n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_err_overrun: got %b want 0", err_overrun); end
        n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
`ifdef UART_TX_CAPTURE_PARITY_EN
        n_checks++; if (err_parity !== 1'b0) begin n_fail++; $display("FAIL reset_err_parity: got %b want 0", err_parity); end
`endif
        @(negedge clk_clk);
        reset_reset = 1'b0;
        repeat (4) @(negedge clk_clk);
    endtask

    task automatic test_single_byte();
        int n;
        n = 0;
        fork
            send_frame(8'hA5, 1'b1, BD);
            begin
                @(negedge clk_clk);
                while (m_valid !== 1'b1 && n < 4 * VALID_LAT) begin
                    @(negedge clk_clk);
                    n++;
                end
            end
        join
        n_checks++; if (n !== VALID_LAT) begin n_fail++; $display("FAIL a5_latency: got %0d want %0d", n, VALID_LAT); end
        n_checks++; if (m_data !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %h want a5", m_data); end
        n_checks++; if (err_frame !== 1'b0 || err_overrun !== 1'b0) begin n_fail++; $display("FAIL a5_errors: got %b%b want 00", err_frame, err_overrun); end
        pop_one();
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL a5_drained: got %b want 0", m_valid); end
    endtask

    task automatic test_glitch();
        @(negedge clk_clk);
        rxd = 1'b0;
        repeat (5) @(negedge clk_clk);
        n_checks++; if (dbg_state !== START) begin n_fail++; $display("FAIL glitch_in_start: got %0d want %0d", dbg_state, START); end
        repeat (BD / 2 - 3 - 5) @(negedge clk_clk);
        rxd = 1'b1;
        repeat (3 * BD) @(negedge clk_clk);
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_no_push: got %b want 0", m_valid); end
        n_checks++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL glitch_no_err: got %b want 0", err_frame); end
        n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL glitch_idle: got %0d want %0d", dbg_state, IDLE); end
    endtask

    task automatic test_break();
        fork
            send_frame(8'h3C, 1'b0, 2000);
            begin
                @(negedge clk_clk);
                repeat (STOP_NEG + 20) @(negedge clk_clk);
                n_checks++; if (err_frame !== 1'b1) begin n_fail++; $display("FAIL break_err_frame: got %b want 1", err_frame); end
                n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL break_discard: got %b want 0", m_valid); end
                n_checks++; if (dbg_state !== BREAK) begin n_fail++; $display("FAIL break_state: got %0d want %0d", dbg_state, BREAK); end
                err_clear = 1'b1;
                @(negedge clk_clk);
                err_clear = 1'b0;
                n_checks++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL break_clear: got %b want 0", err_frame); end
            end
        join
        repeat (BD) @(negedge clk_clk);
        n_checks++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL break_single_err: got %b want 0", err_frame); end
        n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL break_idle: got %0d want %0d", dbg_state, IDLE); end
        send_frame(8'h55, 1'b1, BD);
        repeat (4) @(negedge clk_clk);
        n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h55) begin n_fail++; $display("FAIL after_break_data: got %b/%h want 1/55", m_valid, m_data); end
        n_checks++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL after_break_err: got %b want 0", err_frame); end
        pop_one();
    endtask

    task automatic test_overrun();
        logic [7:0] e;
        m_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, BD);
            if (i < 16) exp_q.push_back(8'(i));
        end
        repeat (BD) @(negedge clk_clk);
        n_checks++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: got %b want 1", err_overrun); end
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            n_checks++; if (m_valid !== 1'b1 || m_data !== e) begin n_fail++; $display("FAIL overrun_drain_%0d: got %b/%h want 1/%h", i, m_valid, m_data, e); end
            pop_one();
        end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_empty: got %b want 0", m_valid); end
    endtask

    task automatic test_full_pop();
        logic [7:0] e;
        err_clear = 1'b1;
        @(negedge clk_clk);
        err_clear = 1'b0;
        n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL full_pop_clear: got %b want 0", err_overrun); end
        for (int i = 0; i < 16; i++) begin
            send_frame(8'h20 + 8'(i), 1'b1, BD);
            exp_q.push_back(8'h20 + 8'(i));
        end
        fork
            send_frame(8'h99, 1'b1, BD);
            begin
                @(negedge clk_clk);
                repeat (STOP_NEG) @(negedge clk_clk);
                m_ready = 1'b1;
                @(negedge clk_clk);
                m_ready = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        exp_q.push_back(8'h99);
        repeat (4) @(negedge clk_clk);
        n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL full_pop_overrun: got %b want 0", err_overrun); end
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            n_checks++; if (m_valid !== 1'b1 || m_data !== e) begin n_fail++; $display("FAIL full_pop_drain_%0d: got %b/%h want 1/%h", i, m_valid, m_data, e); end
            pop_one();
        end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL full_pop_empty: got %b want 0", m_valid); end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h42, 1'b1, BD);
        send_frame(8'h00, 1'b0, BD);
        repeat (BD) @(negedge clk_clk);
        n_checks++; if (m_valid !== 1'b1 || err_frame !== 1'b1) begin n_fail++; $display("FAIL pre_reset_state: got %b/%b want 1/1", m_valid, err_frame); end
        fork
            send_frame(8'hFF, 1'b1, BD);
            begin
                @(negedge clk_clk);
                repeat (3 * BD) @(negedge clk_clk);
                n_checks++; if (dbg_state !== DATA) begin n_fail++; $display("FAIL mid_frame_state: got %0d want %0d", dbg_state, DATA); end
                #2;
                reset_reset = 1'b1;
                #1;
                n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", m_valid); end
                n_checks++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL async_data: got %h want 00", m_data); end
                n_checks++; if (err_frame !== 1'b0 || err_overrun !== 1'b0) begin n_fail++; $display("FAIL async_errors: got %b%b want 00", err_frame, err_overrun); end
                n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL async_state: got %0d want %0d", dbg_state, IDLE); end
                @(negedge clk_clk);
                reset_reset = 1'b0;
            end
        join
        repeat (BD) @(negedge clk_clk);
        n_checks++; if (m_valid !== 1'b0 || dbg_state !== IDLE) begin n_fail++; $display("FAIL post_reset_quiet: got %b/%0d want 0/%0d", m_valid, dbg_state, IDLE); end
        send_frame(8'h81, 1'b1, BD);
        repeat (4) @(negedge clk_clk);
        n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h81) begin n_fail++; $display("FAIL post_reset_data: got %b/%h want 1/81", m_valid, m_data); end
        n_checks++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL post_reset_err: got %b want 0", err_frame); end
        pop_one();
    endtask

`ifdef UART_TX_CAPTURE_PARITY_EN
    task automatic test_parity();
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1, BD);
        repeat (4) @(negedge clk_clk);
        n_checks++; if (err_parity !== 1'b1) begin n_fail++; $display("FAIL parity_bad_flag: got %b want 1", err_parity); end
        n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h07) begin n_fail++; $display("FAIL parity_bad_push: got %b/%h want 1/07", m_valid, m_data); end
        pop_one();
        err_clear = 1'b1;
        @(negedge clk_clk);
        err_clear = 1'b0;
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1, BD);
        repeat (4) @(negedge clk_clk);
        n_checks++; if (err_parity !== 1'b0) begin n_fail++; $display("FAIL parity_good_flag: got %b want 0", err_parity); end
        n_checks++; if (m_valid !== 1'b1 || m_data !== 8'h07) begin n_fail++; $display("FAIL parity_good_push: got %b/%h want 1/07", m_valid, m_data); end
        pop_one();
    endtask
`endif

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_break();
        test_overrun();
        test_full_pop();
        test_reset_mid_frame();
`ifdef UART_TX_CAPTURE_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
